probe_arbiter: RTL and testbench
================================

# probe_arbiter

Packet-atomic N-way round-robin arbiter for the probe uplink tree. It merges N child probe streams onto one 32-bit uplink, holding each grant for a whole probe message: a header word plus `len` payload words. It sits where a node has more than two children, or where messages must not interleave. It also guards the uplink against a child that stalls mid-message.

## Interface
Parameters:
- `N`, 4: number of child ports, 2..16.
- `STALL_W`, 10: stall counter width. A lock aborts after 2^STALL_W−1 idle cycles.

Ports:
- `UCLK` in 1: single clock.
- `URST` in 1: reset, asynchronous, active-low.
- `DATAUPS` in N*32: child words; child i occupies bits [32i+31:32i].
- `DATAVALIDS` in N: child i presents a word.
- `DELAYS` in N: child i has traffic pending.
- `ACKS` out N: word from child i consumed this cycle.
- `DATAUP` out 32: registered uplink word.
- `DATAVALID` out 1: uplink word valid.
- `DELAY` out 1: this subtree has traffic pending.
- `ACK` in 1: parent consumed `DATAUP` this cycle.
- `ABORT` out 1: one-cycle pulse when a lock is dropped by the stall timeout.

## Operation
- Transfer rules:
  - Child transfer: `DATAVALIDS[i] && ACKS[i]`.
  - Uplink transfer: `DATAVALID && ACK`.
  - Output register free: `load = ACK || !DATAVALID`.
- Header word: bits [7:0] = `len`, the payload words that follow (0..255). Bits [31:8] pass through untouched.
- State IDLE:
  - When `load` holds and any `DATAVALIDS` is set, pick the first requester at index ≥ `ptr`, wrapping modulo N.
  - Assert its `ACKS` bit the same cycle and capture its word into `DATAUP`. Set `DATAVALID`=1.
  - `len`=0: stay IDLE and set `ptr` = grant+1 mod N.
  - `len`>0: set `gnt` = grant and `remaining` = len, then go to LOCK.
  - When `load` holds and no child is valid, clear `DATAVALID`.
- State LOCK:
  - Only `ACKS[gnt]` may assert, and only when `load && DATAVALIDS[gnt]`.
  - Each child transfer captures the word and decrements `remaining`.
  - Transfer with `remaining`==1: go to IDLE and set `ptr` = gnt+1.
  - Other children are never acked in LOCK, even while the locked child is idle.
- Stall counter:
  - Cleared on every child transfer and on every entry to LOCK.
  - Increments each LOCK cycle without a child transfer.
  - At all-ones: pulse `ABORT`, go to IDLE, set `ptr` = gnt+1. The partial message is not padded.
- `ACKS` is at most one-hot in every cycle.
- `DELAY` = |`DELAYS` || `DATAVALID` || (state==LOCK).
- Simultaneous `ACK` and new capture in the same cycle:
  - `DATAVALID` stays 1 and `DATAUP` takes the new word, giving back-to-back throughput of one word per cycle.
- Reset (async assert, synchronous-safe deassert by the environment):
  - `DATAVALID`=0, `DATAUP`=32'hAAAA_AAAA, `ACKS`=0, `ABORT`=0.
  - State IDLE, `ptr`=0, `remaining`=0, stall counter=0.
  - A message in flight is discarded; children restart from their own reset.

## Timing
- `ACKS` is combinational from `ACK`, `DATAVALID`, `DATAVALIDS`, state, `gnt`, and `ptr`. There is no combinational path from `DATAUPS` to any output.
- Latency: a child word accepted at cycle t appears on `DATAUP`/`DATAVALID` at t+1.
- Throughput: one word per cycle when `ACK` is held high.
- Grant decisions take effect in the acceptance cycle. A new message header may be accepted in the cycle after the last payload word.
- `ABORT` asserts the cycle after the counter reaches all-ones, together with the return to IDLE.

## Structure
- Package `probe_pkg`:
  - `PROBE_W`=32.
  - `HDR_LEN_LSB`=0, `HDR_LEN_W`=8.
  - `PROBE_RESET_WORD`=32'hAAAA_AAAA.
  - State enum {IDLE, LOCK}.
- Sub-module `rr_pick`: combinational N-bit rotating priority encoder. Inputs `req`[N] and `ptr`[log2 N]; outputs `gnt_oh`[N], `gnt_idx`, and `any`.
- Top module: state register, `remaining`, stall counter, `ptr`, output register, and `DELAY`/`ACKS` gating.

## Test plan
- N=4, `ACK`=1, children 0..3 each send one header with len=0, all valid at once → exactly one `ACKS` bit per cycle in order 0,1,2,3. `DATAUP` carries the four headers on cycles t+1..t+4.
- Child 1 sends header 0x0000_0102 (len=2) plus 2 payloads while child 2 is continuously valid → child 2 is acked only after the second payload. `ptr`=2 afterwards.
- `ACK` held low for 5 cycles while `DATAVALID`=1 → `ACKS`=0 and `DATAUP` stays stable. Accepts resume the cycle `ACK` returns.
- STALL_W=3: child 0 sends header len=3, 1 payload, then drops valid → `ABORT` pulses after 7 idle cycles. Child 1 is then served.
- `URST` asserted mid-message (remaining=4) → outputs immediately reset to the reset values, including `DATAUP`=32'hAAAA_AAAA. After release the next grant starts from child 0.
- `DELAYS`=4'b0100 with no valid data → `DELAY`=1 and `DATAVALID`=0.

Source files
------------

// File: rtl/probe_pkg.sv
// -----------------------------------------------------------------------------
// probe_pkg
// Shared definitions for the probe uplink tree: word width, header layout,
// the uplink reset pattern and the arbiter state encoding.
// -----------------------------------------------------------------------------
package probe_pkg;

    localparam int PROBE_W     = 32;
    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_W   = 8;

    // Idle pattern on the uplink bus after reset; easy to spot on a probe.
    localparam logic [PROBE_W-1:0] PROBE_RESET_WORD = 32'hAAAA_AAAA;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } probe_state_e;

    // Number of payload words that follow a header word.
    function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [PROBE_W-1:0] word);
        return word[HDR_LEN_LSB +: HDR_LEN_W];
    endfunction

endpackage

// File: rtl/probe_arbiter_if.sv
// -----------------------------------------------------------------------------
// probe_arbiter_if
// Bundles the N child probe streams and the single parent uplink of one
// arbiter node.
//   DATAUPS/DATAVALIDS/DELAYS : child words, valids and pending flags (to node)
//   ACKS                      : per-child consume strobes (from node)
//   DATAUP/DATAVALID/DELAY    : uplink word, valid and pending flag (from node)
//   ACK                       : parent consumed DATAUP (to node)
//   ABORT                     : stall-timeout pulse (from node)
// master = the arbiter node, slave = the surrounding environment.
// -----------------------------------------------------------------------------
interface probe_arbiter_if
    import probe_pkg::*;
#(
    parameter int N = 4
);

    logic [N*PROBE_W-1:0] DATAUPS;
    logic [N-1:0]         DATAVALIDS;
    logic [N-1:0]         DELAYS;
    logic [N-1:0]         ACKS;
    logic [PROBE_W-1:0]   DATAUP;
    logic                 DATAVALID;
    logic                 DELAY;
    logic                 ACK;
    logic                 ABORT;

    modport master (
        input  DATAUPS, DATAVALIDS, DELAYS, ACK,
        output ACKS, DATAUP, DATAVALID, DELAY, ABORT
    );

    modport slave (
        output DATAUPS, DATAVALIDS, DELAYS, ACK,
        input  ACKS, DATAUP, DATAVALID, DELAY, ABORT
    );

endinterface

// File: rtl/probe_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating priority encoder. Scans req starting at index ptr and
// wrapping modulo N; the first set bit wins.
//   req     in  N       : request vector
//   ptr     in  IDX_W   : index with highest priority this cycle (< N)
//   gnt_oh  out N       : one-hot winner (all zero when no request)
//   gnt_idx out IDX_W   : winner index (zero when no request)
//   any     out 1       : at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [IDX_W:0]   pos_wide_s;
    logic [IDX_W-1:0] pos_s;
    logic             hit_s;
    logic             found_s;

    // Walk the ring from ptr; the sum gets one extra bit so wrap-around is a
    // single subtract even when N is not a power of two.
    always_comb begin
        gnt_oh     = {N{1'b0}};
        gnt_idx    = {IDX_W{1'b0}};
        found_s    = 1'b0;
        pos_wide_s = {(IDX_W+1){1'b0}};
        pos_s      = {IDX_W{1'b0}};
        hit_s      = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos_wide_s     = {1'b0, ptr} + (IDX_W+1)'(i);
            pos_wide_s     = (pos_wide_s >= (IDX_W+1)'(N)) ? (pos_wide_s - (IDX_W+1)'(N))
                                                          : pos_wide_s;
            pos_s          = pos_wide_s[IDX_W-1:0];
            hit_s          = req[pos_s] & ~found_s;
            gnt_oh[pos_s]  = gnt_oh[pos_s] | hit_s;
            gnt_idx        = hit_s ? pos_s : gnt_idx;
            found_s        = found_s | hit_s;
        end
    end

    assign any = |req;

endmodule

// File: rtl/probe_arbiter.sv
// -----------------------------------------------------------------------------
// probe_arbiter
// Packet-atomic N-way round-robin arbiter. Merges N child probe streams onto
// one registered 32-bit uplink, holding the grant for a whole message (header
// plus len payload words, len in header bits [7:0]). A locked child that
// stops presenting words for 2^STALL_W-1 cycles loses the lock and ABORT
// pulses; the partial message is not padded.
//   UCLK   in  : clock
//   URST   in  : asynchronous active-low reset
//   bus    io  : probe_arbiter_if.master (child streams in, uplink out)
// ACKS is combinational; DATAUP, DATAVALID and ABORT are registered.
// -----------------------------------------------------------------------------
module probe_arbiter
    import probe_pkg::*;
#(
    parameter int N       = 4,
    parameter int STALL_W = 10
) (
    input  logic             UCLK,
    input  logic             URST,
    probe_arbiter_if.master  bus
);

    localparam int                 IDX_W     = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N-1);
    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

    probe_state_e           state_r, state_nxt_s;
    logic [IDX_W-1:0]       ptr_r, ptr_nxt_s;
    logic [IDX_W-1:0]       gnt_r, gnt_nxt_s;
    logic [HDR_LEN_W-1:0]   remaining_r, remaining_nxt_s;
    logic [STALL_W-1:0]     stall_r, stall_nxt_s;
    logic                   abort_r, abort_nxt_s;
    logic [PROBE_W-1:0]     dataup_r;
    logic                   datavalid_r;

    logic                   load_s;
    logic                   xfer_s;
    logic [N-1:0]           acks_s;
    logic [N-1:0]           pick_oh_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic                   pick_any_s;
    logic [PROBE_W-1:0]     child_word_s [N];
    logic [PROBE_W-1:0]     pick_word_s;
    logic [PROBE_W-1:0]     lock_word_s;
    logic [PROBE_W-1:0]     cap_word_s;
    logic [HDR_LEN_W-1:0]   pick_len_s;

    // Next child after idx on the ring.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? {IDX_W{1'b0}} : (idx + IDX_W'(1));
    endfunction

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.DATAVALIDS),
        .ptr     (ptr_r),
        .gnt_oh  (pick_oh_s),
        .gnt_idx (pick_idx_s),
        .any     (pick_any_s)
    );

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign child_word_s[g] = bus.DATAUPS[g*PROBE_W +: PROBE_W];
    end

    // The output register can take a word when it is empty or being drained.
    assign load_s      = bus.ACK | ~datavalid_r;
    assign pick_word_s = child_word_s[pick_idx_s];
    assign lock_word_s = child_word_s[gnt_r];
    assign cap_word_s  = (state_r == LOCK) ? lock_word_s : pick_word_s;
    assign pick_len_s  = hdr_len(pick_word_s);

    // Grant, message tracking and stall timeout decisions for this cycle.
    always_comb begin
        state_nxt_s     = state_r;
        ptr_nxt_s       = ptr_r;
        gnt_nxt_s       = gnt_r;
        remaining_nxt_s = remaining_r;
        stall_nxt_s     = stall_r;
        abort_nxt_s     = 1'b0;
        acks_s          = {N{1'b0}};
        xfer_s          = 1'b0;
        case (state_r)
            IDLE: begin
                stall_nxt_s = {STALL_W{1'b0}};
                if (load_s && pick_any_s) begin
                    acks_s = pick_oh_s;
                    xfer_s = 1'b1;
                    if (pick_len_s == {HDR_LEN_W{1'b0}}) begin
                        // Header-only message: rotate past the winner now.
                        ptr_nxt_s = next_idx(pick_idx_s);
                    end else begin
                        gnt_nxt_s       = pick_idx_s;
                        remaining_nxt_s = pick_len_s;
                        state_nxt_s     = LOCK;
                    end
                end else begin
                    xfer_s = 1'b0;
                end
            end
            LOCK: begin
                if (load_s && bus.DATAVALIDS[gnt_r]) begin
                    acks_s[gnt_r]   = 1'b1;
                    xfer_s          = 1'b1;
                    stall_nxt_s     = {STALL_W{1'b0}};
                    remaining_nxt_s = remaining_r - HDR_LEN_W'(1);
                    if (remaining_r == HDR_LEN_W'(1)) begin
                        state_nxt_s = IDLE;
                        ptr_nxt_s   = next_idx(gnt_r);
                    end else begin
                        state_nxt_s = LOCK;
                    end
                end else if (stall_r == STALL_MAX) begin
                    // Locked child went quiet too long: drop the lock.
                    abort_nxt_s     = 1'b1;
                    state_nxt_s     = IDLE;
                    ptr_nxt_s       = next_idx(gnt_r);
                    remaining_nxt_s = {HDR_LEN_W{1'b0}};
                    stall_nxt_s     = {STALL_W{1'b0}};
                end else begin
                    stall_nxt_s = stall_r + STALL_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Arbiter state: FSM, rotation pointer, locked child, counters, abort.
    always_ff @(posedge UCLK or negedge URST) begin
        if (!URST) begin
            state_r     <= IDLE;
            ptr_r       <= {IDX_W{1'b0}};
            gnt_r       <= {IDX_W{1'b0}};
            remaining_r <= {HDR_LEN_W{1'b0}};
            stall_r     <= {STALL_W{1'b0}};
            abort_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            gnt_r       <= gnt_nxt_s;
            remaining_r <= remaining_nxt_s;
            stall_r     <= stall_nxt_s;
            abort_r     <= abort_nxt_s;
        end
    end

    // Uplink output register; a drain and a capture in the same cycle keep
    // DATAVALID high so the uplink streams one word per cycle.
    always_ff @(posedge UCLK or negedge URST) begin
        if (!URST) begin
            dataup_r    <= PROBE_RESET_WORD;
            datavalid_r <= 1'b0;
        end else if (load_s) begin
            datavalid_r <= xfer_s;
            if (xfer_s) begin
                dataup_r <= cap_word_s;
            end
        end
    end

    // ACKS is held low while reset is asserted so no child pops a word that
    // the cleared output register would lose.
    assign bus.ACKS      = acks_s & {N{URST}};
    assign bus.DATAUP    = dataup_r;
    assign bus.DATAVALID = datavalid_r;
    assign bus.ABORT     = abort_r;
    assign bus.DELAY     = (|bus.DELAYS) | datavalid_r | (state_r == LOCK);

endmodule

// File: tb/tb_probe_arbiter.sv
// -----------------------------------------------------------------------------
// tb_probe_arbiter
// Self-checking bench for probe_arbiter (N=4, STALL_W=3). Children are modelled
// as word queues that present their head word and pop it when acked; expected
// uplink words go into a scoreboard queue and are compared at every uplink
// transfer.
// -----------------------------------------------------------------------------
module tb_probe_arbiter;
    import probe_pkg::*;

    localparam int N = 4;

    logic uclk = 1'b0;
    logic urst = 1'b1;

    always #5 uclk = ~uclk;

    probe_arbiter_if #(.N(N)) bus ();

    probe_arbiter #(.N(N), .STALL_W(3)) dut (
        .UCLK (uclk),
        .URST (urst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] cq [N][$];
    logic [31:0] exp_q [$];
    int          gnt_log [$];
    int          exp_g [$];

    logic [N-1:0] acks_seen;
    logic         dv_seen;
    logic         abort_seen;
    logic         delay_seen;
    logic [31:0]  up_seen;

    typedef struct {
        logic         ack;
        logic [N-1:0] exp_acks;
        logic         exp_dv;
        logic [31:0]  exp_up;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_children();
        for (int i = 0; i < N; i++) begin
            bus.DATAVALIDS[i]      = (cq[i].size() > 0);
            bus.DATAUPS[i*32 +: 32] = (cq[i].size() > 0) ? cq[i][0] : 32'hDEAD_0000;
        end
    endtask

    // One clock: sample combinational outputs at negedge, advance past the
    // posedge, pop acked child words, score any uplink transfer.
    task automatic cycle();
        logic        up_xfer;
        logic [31:0] exp_w;
        @(negedge uclk);
        acks_seen  = bus.ACKS;
        dv_seen    = bus.DATAVALID;
        up_seen    = bus.DATAUP;
        abort_seen = bus.ABORT;
        delay_seen = bus.DELAY;
        up_xfer    = bus.DATAVALID && bus.ACK;
        chk("acks_onehot", 32'($onehot0(acks_seen)), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (acks_seen[i]) gnt_log.push_back(i);
        end
        @(posedge uclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acks_seen[i] && cq[i].size() > 0) void'(cq[i].pop_front());
        end
        if (up_xfer) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra_word actual=0x%08h expected=none", up_seen);
            end else begin
                exp_w = exp_q.pop_front();
                chk("sb_uplink", up_seen, exp_w);
            end
        end
        drive_children();
    endtask

    function automatic logic idle_now();
        logic b;
        b = (exp_q.size() == 0) && !bus.DATAVALID;
        for (int i = 0; i < N; i++) b = b && (cq[i].size() == 0);
        return b;
    endfunction

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!idle_now() && n < max_cycles) begin
            cycle();
            n++;
        end
        chk(name, 32'(idle_now()), 32'd1);
    endtask

    task automatic chk_grants(input string name);
        chk({name, "_count"}, 32'(gnt_log.size()), 32'(exp_g.size()));
        for (int i = 0; i < exp_g.size() && i < gnt_log.size(); i++) begin
            chk(name, 32'(gnt_log[i]), 32'(exp_g[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.DATAUPS    = {(N*32){1'b0}};
        bus.DATAVALIDS = {N{1'b0}};
        bus.DELAYS     = {N{1'b0}};
        bus.ACK        = 1'b1;

        // Round-robin over four header-only messages, then ACK backpressure.
        vecs[0]  = '{1'b1, 4'b0001, 1'b1, 32'hC0AB_CD00};
        vecs[1]  = '{1'b1, 4'b0010, 1'b1, 32'hC1AB_CD00};
        vecs[2]  = '{1'b1, 4'b0100, 1'b1, 32'hC2AB_CD00};
        vecs[3]  = '{1'b1, 4'b1000, 1'b1, 32'hC3AB_CD00};
        vecs[4]  = '{1'b1, 4'b0000, 1'b0, 32'h0000_0000};
        vecs[5]  = '{1'b1, 4'b0001, 1'b1, 32'h5A5A_0000};
        vecs[6]  = '{1'b0, 4'b0000, 1'b1, 32'h5A5A_0000};
        vecs[7]  = '{1'b0, 4'b0000, 1'b1, 32'h5A5A_0000};
        vecs[8]  = '{1'b0, 4'b0000, 1'b1, 32'h5A5A_0000};
        vecs[9]  = '{1'b0, 4'b0000, 1'b1, 32'h5A5A_0000};
        vecs[10] = '{1'b0, 4'b0000, 1'b1, 32'h5A5A_0000};
        vecs[11] = '{1'b1, 4'b0001, 1'b1, 32'hA5A5_0000};
        vecs[12] = '{1'b1, 4'b0000, 1'b0, 32'h0000_0000};

        #1 urst = 1'b0;
        #2;
        chk("reset_dv",    32'(bus.DATAVALID), 32'd0);
        chk("reset_up",    bus.DATAUP, 32'hAAAA_AAAA);
        chk("reset_acks",  32'(bus.ACKS), 32'd0);
        chk("reset_abort", 32'(bus.ABORT), 32'd0);
        chk("reset_delay", 32'(bus.DELAY), 32'd0);
        @(negedge uclk);
        urst = 1'b1;
        @(posedge uclk);
        #1;

        for (int i = 0; i < N; i++) begin
            cq[i].push_back(vecs[i].exp_up);
            exp_q.push_back(vecs[i].exp_up);
        end
        drive_children();
        for (int i = 0; i < 13; i++) begin
            if (i == 5) begin
                cq[0].push_back(32'h5A5A_0000);
                cq[0].push_back(32'hA5A5_0000);
                exp_q.push_back(32'h5A5A_0000);
                exp_q.push_back(32'hA5A5_0000);
                drive_children();
            end
            bus.ACK = vecs[i].ack;
            cycle();
            chk($sformatf("vec%0d_acks", i), 32'(acks_seen), 32'(vecs[i].exp_acks));
            chk($sformatf("vec%0d_dv", i), 32'(bus.DATAVALID), 32'(vecs[i].exp_dv));
            if (vecs[i].exp_dv) chk($sformatf("vec%0d_up", i), bus.DATAUP, vecs[i].exp_up);
        end
        bus.ACK = 1'b1;

        // Locked message from child 1 while child 2 waits.
        gnt_log.delete();
        cq[1].push_back(32'h0000_0102);
        cq[1].push_back(32'h1111_0001);
        cq[1].push_back(32'h1111_0002);
        cq[1].push_back(32'h1B00_0000);
        cq[2].push_back(32'h2C00_0000);
        exp_q.push_back(32'h0000_0102);
        exp_q.push_back(32'h1111_0001);
        exp_q.push_back(32'h1111_0002);
        exp_q.push_back(32'h2C00_0000);
        exp_q.push_back(32'h1B00_0000);
        drive_children();
        drain("lock_drain", 30);
        exp_g = '{1, 1, 1, 2, 1};
        chk_grants("lock_order");

        // Reset in the middle of a len=4 message from child 3.
        gnt_log.delete();
        cq[3].push_back(32'h3300_0004);
        cq[3].push_back(32'h3301_0000);
        cq[3].push_back(32'h3302_0000);
        cq[3].push_back(32'h3303_0000);
        cq[3].push_back(32'h3304_0000);
        drive_children();
        cycle();
        chk("rst_hdr_acks", 32'(acks_seen), 32'h8);
        chk("rst_hdr_up", bus.DATAUP, 32'h3300_0004);
        #1 urst = 1'b0;
        #1;
        chk("rst_mid_dv",    32'(bus.DATAVALID), 32'd0);
        chk("rst_mid_up",    bus.DATAUP, 32'hAAAA_AAAA);
        chk("rst_mid_acks",  32'(bus.ACKS), 32'd0);
        chk("rst_mid_abort", 32'(bus.ABORT), 32'd0);
        for (int i = 0; i < N; i++) cq[i].delete();
        exp_q.delete();
        drive_children();
        @(negedge uclk);
        urst = 1'b1;
        @(posedge uclk);
        #1;
        gnt_log.delete();
        cq[0].push_back(32'h0A00_0000);
        cq[3].push_back(32'h3A00_0000);
        exp_q.push_back(32'h0A00_0000);
        exp_q.push_back(32'h3A00_0000);
        drive_children();
        drain("rst_drain", 20);
        exp_g = '{0, 3};
        chk_grants("rst_order");

        // Child 0 stalls mid-message; lock must drop after 7 idle cycles.
        gnt_log.delete();
        cq[0].push_back(32'h0BAD_0003);
        cq[0].push_back(32'hCAFE_0001);
        cq[1].push_back(32'h1E00_0000);
        exp_q.push_back(32'h0BAD_0003);
        exp_q.push_back(32'hCAFE_0001);
        exp_q.push_back(32'h1E00_0000);
        drive_children();
        cycle();
        chk("stall_hdr_acks", 32'(acks_seen), 32'h1);
        cycle();
        chk("stall_pay_acks", 32'(acks_seen), 32'h1);
        for (int n = 1; n <= 10; n++) begin
            cycle();
            chk($sformatf("stall_abort_c%0d", n), 32'(abort_seen), 32'(n == 9));
            if (n <= 8) begin
                chk($sformatf("stall_no_ack_c%0d", n), 32'(acks_seen), 32'd0);
            end else if (n == 9) begin
                chk("stall_serve_child1", 32'(acks_seen), 32'h2);
            end
            if (n == 3) begin
                chk("stall_lock_delay", 32'(delay_seen), 32'd1);
                chk("stall_lock_dv", 32'(dv_seen), 32'd0);
            end
        end
        drain("stall_drain", 20);

        // DELAY driven by pending children alone.
        bus.DELAYS = 4'b0100;
        cycle();
        cycle();
        chk("delays_delay", 32'(delay_seen), 32'd1);
        chk("delays_dv", 32'(dv_seen), 32'd0);
        bus.DELAYS = 4'b0000;
        cycle();
        chk("delays_clear", 32'(delay_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
